alarm_trigger: RTL and testbench

//  Consumes the BCD alarm setting from the alarm-set block and the running BCD time from the clock

---
 rtl/alarm_pkg.sv | 13 +
 rtl/rise_detect.sv | 26 ++
 rtl/alarm_trigger.sv | 147 ++++++++++++++
 tb/tb_alarm_trigger.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm trigger block.
package alarm_pkg;

  localparam int unsigned BcdW = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnooze  = 2'd2,
    StDone    = 2'd3
  } alarm_state_t;

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector: one history register plus AND-NOT.
module rise_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;
  logic seen_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q    <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      d_q    <= d_i;
      seen_q <= 1'b1;
    end
  end

  // The history must be sampled once after reset before any edge counts, so a level
  // already high when reset releases is not mistaken for a rise.
  assign rise_o = seen_q & d_i & ~d_q;

endmodule

// File: rtl/alarm_trigger.sv
// Compares BCD time against the alarm setting and drives the buzzer with ring timeout,
// snooze and stop handling; all timing counted in sec_tick enables.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned RingSeconds   = 60,
  parameter int unsigned SnoozeSeconds = 300,
  parameter int unsigned CntW          = 9
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            sec_tick_i,
  input  logic            alarm_on_i,
  input  logic            snooze_btn_i,
  input  logic            stop_btn_i,
  input  logic [BcdW-1:0] time_unit_min_i,
  input  logic [BcdW-1:0] time_tens_min_i,
  input  logic [BcdW-1:0] time_unit_hour_i,
  input  logic [BcdW-1:0] time_tens_hour_i,
  input  logic [BcdW-1:0] alarm_unit_min_i,
  input  logic [BcdW-1:0] alarm_tens_min_i,
  input  logic [BcdW-1:0] alarm_unit_hour_i,
  input  logic [BcdW-1:0] alarm_tens_hour_i,
  output logic            buzzer_o,
  output logic            ringing_o,
  output logic            snoozing_o
);

  localparam logic [CntW-1:0] RingLast   = CntW'(RingSeconds - 1);
  localparam logic [CntW-1:0] SnoozeLast = CntW'(SnoozeSeconds - 1);

  alarm_state_t    state_q, state_d;
  logic [CntW-1:0] sec_cnt_q, sec_cnt_d;
  logic            buzzer_q, buzzer_d;
  logic            ringing_q, snoozing_q;
  logic            match, match_rise, snz_p, stp_p;

  assign match = {time_tens_hour_i, time_unit_hour_i, time_tens_min_i, time_unit_min_i} ==
                 {alarm_tens_hour_i, alarm_unit_hour_i, alarm_tens_min_i, alarm_unit_min_i};

  rise_detect u_match_rise (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (match),
    .rise_o (match_rise)
  );

  rise_detect u_snooze_rise (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (snooze_btn_i),
    .rise_o (snz_p)
  );

  rise_detect u_stop_rise (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (stop_btn_i),
    .rise_o (stp_p)
  );

  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    buzzer_d  = 1'b0;
    if (!alarm_on_i) begin
      state_d   = StIdle;
      sec_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (match_rise) begin
            state_d   = StRinging;
            sec_cnt_d = '0;
            buzzer_d  = 1'b1;
          end
        end
        StRinging: begin
          buzzer_d = buzzer_q;
          if (stp_p) begin
            state_d   = StDone;
            sec_cnt_d = '0;
            buzzer_d  = 1'b0;
          end else if (snz_p) begin
            state_d   = StSnooze;
            sec_cnt_d = '0;
            buzzer_d  = 1'b0;
          end else if (sec_tick_i) begin
            if (sec_cnt_q == RingLast) begin
              state_d   = StDone;
              sec_cnt_d = '0;
              buzzer_d  = 1'b0;
            end else begin
              sec_cnt_d = sec_cnt_q + CntW'(1);
              buzzer_d  = ~buzzer_q;
            end
          end
        end
        StSnooze: begin
          if (stp_p) begin
            state_d   = StDone;
            sec_cnt_d = '0;
          end else if (sec_tick_i) begin
            if (sec_cnt_q == SnoozeLast) begin
              state_d   = StRinging;
              sec_cnt_d = '0;
              buzzer_d  = 1'b1;
            end else begin
              sec_cnt_d = sec_cnt_q + CntW'(1);
            end
          end
        end
        StDone: begin
          // Held until the minute changes so the same match cannot retrigger.
          if (!match) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d   = StIdle;
          sec_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      sec_cnt_q  <= '0;
      buzzer_q   <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_cnt_q  <= sec_cnt_d;
      buzzer_q   <= buzzer_d;
      ringing_q  <= (state_d == StRinging);
      snoozing_q <= (state_d == StSnooze);
    end
  end

  assign buzzer_o   = buzzer_q;
  assign ringing_o  = ringing_q;
  assign snoozing_o = snoozing_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed plus randomized bench for alarm_trigger against a seconds-elapsed reference model.
module tb_alarm_trigger;

  localparam int RingS = 4;
  localparam int SnzS  = 3;

  localparam int MIdle = 0;
  localparam int MRing = 1;
  localparam int MSnz  = 2;
  localparam int MDone = 3;

  localparam logic [15:0] Alm = 16'h0730;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sec_tick = 1'b0;
  logic        alarm_on = 1'b0;
  logic        snooze_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic [15:0] tim = 16'h0000;
  logic [15:0] alm = Alm;
  logic        buzzer, ringing, snoozing;

  int checks = 0;
  int failures = 0;

  // Reference model: mode, ticks elapsed in mode, previous input levels (-1 = not yet seen).
  int m_mode = MIdle;
  int m_ticks = 0;
  int prev_match = -1;
  int prev_snz = -1;
  int prev_stp = -1;

  alarm_trigger #(
    .RingSeconds   (RingS),
    .SnoozeSeconds (SnzS),
    .CntW          (9)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .sec_tick_i        (sec_tick),
    .alarm_on_i        (alarm_on),
    .snooze_btn_i      (snooze_btn),
    .stop_btn_i        (stop_btn),
    .time_unit_min_i   (tim[3:0]),
    .time_tens_min_i   (tim[7:4]),
    .time_unit_hour_i  (tim[11:8]),
    .time_tens_hour_i  (tim[15:12]),
    .alarm_unit_min_i  (alm[3:0]),
    .alarm_tens_min_i  (alm[7:4]),
    .alarm_unit_hour_i (alm[11:8]),
    .alarm_tens_hour_i (alm[15:12]),
    .buzzer_o          (buzzer),
    .ringing_o         (ringing),
    .snoozing_o        (snoozing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit rose(input int prev, input bit now);
    return now && (prev == 0);
  endfunction

  function automatic void model_reset();
    m_mode     = MIdle;
    m_ticks    = 0;
    prev_match = -1;
    prev_snz   = -1;
    prev_stp   = -1;
  endfunction

  function automatic void model_clk();
    bit mt, r, sp, tp;
    mt = (tim == alm);
    r  = rose(prev_match, mt);
    sp = rose(prev_snz, snooze_btn);
    tp = rose(prev_stp, stop_btn);
    prev_match = int'(mt);
    prev_snz   = int'(snooze_btn);
    prev_stp   = int'(stop_btn);
    if (!alarm_on) begin
      m_mode  = MIdle;
      m_ticks = 0;
    end else if (m_mode == MIdle) begin
      if (r) begin
        m_mode  = MRing;
        m_ticks = 0;
      end
    end else if (m_mode == MRing) begin
      if (tp) m_mode = MDone;
      else if (sp) begin
        m_mode  = MSnz;
        m_ticks = 0;
      end else if (sec_tick) begin
        m_ticks++;
        if (m_ticks >= RingS) m_mode = MDone;
      end
    end else if (m_mode == MSnz) begin
      if (tp) m_mode = MDone;
      else if (sec_tick) begin
        m_ticks++;
        if (m_ticks >= SnzS) begin
          m_mode  = MRing;
          m_ticks = 0;
        end
      end
    end else if (!mt) begin
      m_mode = MIdle;
    end
  endfunction

  function automatic bit exp_buzzer();
    // Buzzer starts high on entering RINGING and flips once per elapsed second.
    return (m_mode == MRing) && (m_ticks % 2 == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
    check("ringing", {31'd0, ringing}, {31'd0, m_mode == MRing});
    check("snoozing", {31'd0, snoozing}, {31'd0, m_mode == MSnz});
    check("buzzer", {31'd0, buzzer}, {31'd0, exp_buzzer()});
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic start_ring();
    tim = 16'h0729;
    step();
    tim = Alm;
    step();
    check("start_ring", {31'd0, ringing}, 32'd1);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_ring"}, {31'd0, ringing}, 32'd0);
    check({tag, "_snz"}, {31'd0, snoozing}, 32'd0);
    check({tag, "_buz"}, {31'd0, buzzer}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset with arbitrary inputs, then release while time already matches.
    tim        = 16'($urandom);
    sec_tick   = 1'b1;
    snooze_btn = 1'b1;
    alarm_on   = 1'b1;
    #23;
    outputs_zero("t1_reset");
    sec_tick   = 1'b0;
    snooze_btn = 1'b0;
    tim        = Alm;
    model_reset();
    release_reset();
    repeat (3) step();
    check("t1_no_ring", {31'd0, ringing}, 32'd0);

    // 2: normal ring with timeout.
    start_ring();
    check("t2_buz_on", {31'd0, buzzer}, 32'd1);
    repeat (3) begin
      step();
      tick();
    end
    check("t2_buz_after3", {31'd0, buzzer}, 32'd0);
    check("t2_still_ring", {31'd0, ringing}, 32'd1);
    tick();
    outputs_zero("t2_timeout");
    tim = 16'h0731;
    repeat (2) step();

    // 3: snooze, ring again after the snooze period, then stop.
    start_ring();
    snooze_btn = 1'b1;
    step();
    check("t3_snz", {31'd0, snoozing}, 32'd1);
    check("t3_buz_off", {31'd0, buzzer}, 32'd0);
    snooze_btn = 1'b0;
    repeat (3) tick();
    check("t3_rering", {31'd0, ringing}, 32'd1);
    stop_btn = 1'b1;
    step();
    outputs_zero("t3_stop");
    stop_btn = 1'b0;
    tim = 16'h0731;
    repeat (2) step();

    // 4: simultaneous stop/snooze; snooze press ignored while snoozing.
    start_ring();
    stop_btn   = 1'b1;
    snooze_btn = 1'b1;
    step();
    outputs_zero("t4_both");
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    start_ring();
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    step();
    snooze_btn = 1'b1;
    step();
    check("t4_snz_hold", {31'd0, snoozing}, 32'd1);
    snooze_btn = 1'b0;
    stop_btn   = 1'b1;
    step();
    stop_btn = 1'b0;

    // 5: disarm while ringing, rearm on a still-matching time.
    start_ring();
    alarm_on = 1'b0;
    step();
    outputs_zero("t5_off");
    alarm_on = 1'b1;
    repeat (3) step();
    check("t5_no_ring", {31'd0, ringing}, 32'd0);

    // 6: asynchronous reset mid-snooze.
    start_ring();
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    tick();
    check("t6_in_snz", {31'd0, snoozing}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    outputs_zero("t6_reset");
    check("t6_cnt", 32'(dut.sec_cnt_q), 32'd0);
    model_reset();
    release_reset();
    step();

    // Randomized phase around the alarm minute.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) begin
        case ($urandom_range(2))
          0: tim = 16'h0729;
          1: tim = Alm;
          default: tim = 16'h0731;
        endcase
      end
      sec_tick = ($urandom_range(2) == 0);
      if ($urandom_range(19) == 0) snooze_btn = ~snooze_btn;
      if ($urandom_range(39) == 0) stop_btn = ~stop_btn;
      if ($urandom_range(99) == 0) alarm_on = ~alarm_on;
      if ($urandom_range(599) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        outputs_zero("rand_reset");
        model_reset();
        release_reset();
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
